operand_capture_seq: RTL and testbench

- Parametrised operand-capture sequencer for the calculator datapath.
- Watches an active-low one-hot register-select key bus and latches the chosen register into the next free operand slot.
- Presents all captured slots packed onto one result bus, with a valid flag once every slot is filled.
- Sits between the register file/PC and the ALU/display; generalises the fixed two-operand, flag-steered selector to N sources, K slots and auto-sequencing.

---
 rtl/operand_capture_seq.sv | 163 ++++++++++++++++
 tb/tb_operand_capture_seq.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/operand_capture_seq.sv
// operand_capture_seq
//
// Operand-capture sequencer for the calculator datapath. It watches an
// active-low one-hot register-select key bus and, on each fresh key press,
// latches the chosen source register into the next free operand slot. All
// slots are presented packed on one result bus, with a valid flag once every
// slot has been filled.
//
// Parameters:
//   DW        width of each source register and each operand slot
//   NREG      number of selectable sources (bit i of sel_n selects source i)
//   NOPS      number of operand slots (>= 1)
//   FULL_MODE press while full: 0 = ignore until clear, 1 = restart at slot 0
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     synchronous active-low reset
//   src_flat  source registers, source i at bits [i*DW +: DW]
//   sel_n     active-low one-hot select keys, all ones = idle
//   clear     synchronous clear of slots and sequencer, active high
//   res       packed slots, slot 0 in the MSBs, slot NOPS-1 in the LSBs
//   op_valid  high while all NOPS slots hold captured values
//   slot_idx  index of the next slot to be written (NOPS when full)
//   err       one-cycle pulse on an invalid (multi-key) select pattern

module operand_capture_seq #(
    parameter int DW        = 8,
    parameter int NREG      = 5,
    parameter int NOPS      = 2,
    parameter int FULL_MODE = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NREG*DW-1:0]            src_flat,
    input  logic [NREG-1:0]               sel_n,
    input  logic                          clear,
    output logic [NOPS*DW-1:0]            res,
    output logic                          op_valid,
    output logic [$clog2(NOPS+1)-1:0]     slot_idx,
    output logic                          err
);

    localparam int IW = $clog2(NOPS + 1);

    typedef enum logic {
        FILL,
        FULL
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [IW-1:0]   idx_next;
    logic [NREG-1:0] sel_prev;
    logic [NREG-1:0] keys_low;
    logic            prev_idle;
    logic            one_low;
    logic            multi_low;
    logic            press;
    logic            bad;
    logic            wr_en;
    logic            restart;
    logic [DW-1:0]   sel_val;
    logic [DW-1:0]   slots [NOPS];

    // A press or an error is only recognised on the transition out of idle,
    // so a held key (or a key change while another is held) does nothing.
    assign keys_low  = ~sel_n;
    assign prev_idle = &sel_prev;
    assign one_low   = (keys_low != '0) && ((keys_low & (keys_low - NREG'(1))) == '0);
    assign multi_low = (keys_low != '0) && !one_low;
    assign press     = prev_idle && one_low;
    assign bad       = prev_idle && multi_low;

    // With a single key low this OR-reduction picks exactly that source.
    always_comb begin
        sel_val = '0;
        for (int i = 0; i < NREG; i++) begin
            if (!sel_n[i]) begin
                sel_val = sel_val | src_flat[i*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= FILL;
            slot_idx <= '0;
            sel_prev <= '1;
            err      <= 1'b0;
        end else begin
            state    <= state_next;
            slot_idx <= idx_next;
            sel_prev <= sel_n;
            err      <= bad;
        end
    end

    // Clear has priority over a simultaneous press; the press is discarded.
    always_comb begin
        state_next = state;
        idx_next   = slot_idx;
        wr_en      = 1'b0;
        restart    = 1'b0;
        if (clear) begin
            state_next = FILL;
            idx_next   = '0;
        end else if (press) begin
            unique case (state)
                FILL: begin
                    wr_en    = 1'b1;
                    idx_next = slot_idx + IW'(1);
                    if (slot_idx == IW'(NOPS - 1)) begin
                        state_next = FULL;
                    end
                end
                FULL: begin
                    if (FULL_MODE != 0) begin
                        restart = 1'b1;
                        if (NOPS == 1) begin
                            idx_next   = IW'(NOPS);
                            state_next = FULL;
                        end else begin
                            idx_next   = IW'(1);
                            state_next = FILL;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Slot storage. A restart writes slot 0 and wipes the rest so a partly
    // refilled operand set never shows stale values.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            for (int k = 0; k < NOPS; k++) begin
                slots[k] <= '0;
            end
        end else if (wr_en) begin
            for (int k = 0; k < NOPS; k++) begin
                if (slot_idx == IW'(k)) begin
                    slots[k] <= sel_val;
                end
            end
        end else if (restart) begin
            slots[0] <= sel_val;
            for (int k = 1; k < NOPS; k++) begin
                slots[k] <= '0;
            end
        end
    end

    always_comb begin
        res = '0;
        for (int k = 0; k < NOPS; k++) begin
            res[(NOPS-1-k)*DW +: DW] = slots[k];
        end
    end

    assign op_valid = (state == FULL);

endmodule

// File: tb/tb_operand_capture_seq.sv
// tb_operand_capture_seq
//
// Drives three instances from one shared key bus: the default two-slot
// ignore-when-full build, a two-slot restart-when-full build, and a three-slot
// four-bit build. A reference model tracks each instance as a list of captured
// values plus a fill count and predicts every output after every edge.

module tb_operand_capture_seq;

    logic        clk;
    logic        rst_n;
    logic        clear;
    logic [4:0]  sel_n;
    logic [39:0] src8;
    logic [19:0] src4;

    logic [15:0] res0, res1;
    logic [11:0] res2;
    logic        op_valid0, op_valid1, op_valid2;
    logic [1:0]  slot_idx0, slot_idx1, slot_idx2;
    logic        err0, err1, err2;

    int tests_run;
    int tests_failed;

    // Reference model state
    int          m_slots [3][3];
    int          m_cnt   [3];
    logic        m_err;
    logic [4:0]  m_prev;
    int          p_nops  [3] = '{2, 2, 3};
    int          p_dw    [3] = '{8, 8, 4};
    int          p_fmode [3] = '{0, 1, 0};

    operand_capture_seq #(.DW(8), .NREG(5), .NOPS(2), .FULL_MODE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .src_flat(src8), .sel_n(sel_n), .clear(clear),
        .res(res0), .op_valid(op_valid0), .slot_idx(slot_idx0), .err(err0)
    );

    operand_capture_seq #(.DW(8), .NREG(5), .NOPS(2), .FULL_MODE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .src_flat(src8), .sel_n(sel_n), .clear(clear),
        .res(res1), .op_valid(op_valid1), .slot_idx(slot_idx1), .err(err1)
    );

    operand_capture_seq #(.DW(4), .NREG(5), .NOPS(3), .FULL_MODE(0)) dut2 (
        .clk(clk), .rst_n(rst_n), .src_flat(src4), .sel_n(sel_n), .clear(clear),
        .res(res2), .op_valid(op_valid2), .slot_idx(slot_idx2), .err(err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Model update for one rising edge, using the inputs present at that edge.
    task automatic modelStep();
        int nlow;
        int key;
        int val;
        nlow = 0;
        key  = 0;
        for (int b = 0; b < 5; b++) begin
            if (!sel_n[b]) begin
                nlow++;
                key = b;
            end
        end
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                m_cnt[i] = 0;
                for (int k = 0; k < 3; k++) m_slots[i][k] = 0;
            end
            m_err  = 1'b0;
            m_prev = 5'h1f;
            return;
        end
        m_err = (m_prev == 5'h1f) && (nlow >= 2);
        for (int i = 0; i < 3; i++) begin
            if (clear) begin
                m_cnt[i] = 0;
                for (int k = 0; k < 3; k++) m_slots[i][k] = 0;
            end else if (m_prev == 5'h1f && nlow == 1) begin
                val = (p_dw[i] == 8) ? int'(src8[key*8 +: 8]) : int'(src4[key*4 +: 4]);
                if (m_cnt[i] < p_nops[i]) begin
                    m_slots[i][m_cnt[i]] = val;
                    m_cnt[i]++;
                end else if (p_fmode[i] == 1) begin
                    for (int k = 0; k < 3; k++) m_slots[i][k] = 0;
                    m_slots[i][0] = val;
                    m_cnt[i] = 1;
                end
            end
        end
        m_prev = sel_n;
    endtask

    function automatic logic [31:0] modelRes(input int i);
        logic [31:0] e;
        e = 0;
        for (int k = 0; k < p_nops[i]; k++) begin
            e = (e << p_dw[i]) | 32'(m_slots[i][k]);
        end
        return e;
    endfunction

    task automatic compareAll();
        checkOutput("dut0.res",      32'(res0),      modelRes(0));
        checkOutput("dut0.op_valid", 32'(op_valid0), 32'(m_cnt[0] == p_nops[0]));
        checkOutput("dut0.slot_idx", 32'(slot_idx0), 32'(m_cnt[0]));
        checkOutput("dut0.err",      32'(err0),      32'(m_err));
        checkOutput("dut1.res",      32'(res1),      modelRes(1));
        checkOutput("dut1.op_valid", 32'(op_valid1), 32'(m_cnt[1] == p_nops[1]));
        checkOutput("dut1.slot_idx", 32'(slot_idx1), 32'(m_cnt[1]));
        checkOutput("dut1.err",      32'(err1),      32'(m_err));
        checkOutput("dut2.res",      32'(res2),      modelRes(2));
        checkOutput("dut2.op_valid", 32'(op_valid2), 32'(m_cnt[2] == p_nops[2]));
        checkOutput("dut2.slot_idx", 32'(slot_idx2), 32'(m_cnt[2]));
        checkOutput("dut2.err",      32'(err2),      32'(m_err));
    endtask

    // One clock of stimulus: inputs change on the falling edge, the model
    // advances on the rising edge, outputs are compared just after it.
    task automatic applyStimulus(input logic [4:0] s, input logic c, input logic r);
        @(negedge clk);
        sel_n = s;
        clear = c;
        rst_n = r;
        @(posedge clk);
        modelStep();
        #1;
        compareAll();
    endtask

    function automatic logic [4:0] randomKeys();
        int pick;
        pick = $urandom_range(0, 99);
        if (pick < 50) return 5'h1f;
        if (pick < 85) return ~(5'b00001 << $urandom_range(0, 4));
        if (pick < 95) return ~((5'b00001 << $urandom_range(0, 4)) | (5'b00001 << $urandom_range(0, 4)));
        return 5'($urandom);
    endfunction

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n = 1'b0;
        clear = 1'b0;
        sel_n = 5'h1f;
        src8  = {8'h56, 8'h7F, 8'h9A, 8'h34, 8'h12};
        src4  = {4'h0, 4'h0, 4'h0, 4'h3, 4'hA};
        m_err  = 1'b0;
        m_prev = 5'h1f;
        for (int i = 0; i < 3; i++) begin
            m_cnt[i] = 0;
            for (int k = 0; k < 3; k++) m_slots[i][k] = 0;
        end

        applyStimulus(5'h1f, 1'b0, 1'b0);
        applyStimulus(5'h1f, 1'b0, 1'b0);
        checkOutput("reset res", 32'(res0), 32'h0);

        // First press of R0, held for three cycles
        applyStimulus(5'b11110, 1'b0, 1'b1);
        checkOutput("press R0 res", 32'(res0), 32'h1200);
        checkOutput("press R0 idx", 32'(slot_idx0), 32'd1);
        applyStimulus(5'b11110, 1'b0, 1'b1);
        applyStimulus(5'b11110, 1'b0, 1'b1);
        checkOutput("hold no repeat", 32'(res0), 32'h1200);
        applyStimulus(5'h1f, 1'b0, 1'b1);
        applyStimulus(5'b11101, 1'b0, 1'b1);
        checkOutput("press R1 res", 32'(res0), 32'h1234);
        checkOutput("press R1 valid", 32'(op_valid0), 32'd1);
        applyStimulus(5'b11101, 1'b0, 1'b1);
        applyStimulus(5'h1f, 1'b0, 1'b1);

        // Press while full: ignored by mode 0, restarts mode 1
        applyStimulus(5'b11011, 1'b0, 1'b1);
        checkOutput("full ignore res", 32'(res0), 32'h1234);
        checkOutput("full restart res", 32'(res1), 32'h9A00);
        checkOutput("full restart idx", 32'(slot_idx1), 32'd1);
        checkOutput("full restart valid", 32'(op_valid1), 32'd0);
        applyStimulus(5'h1f, 1'b0, 1'b1);
        applyStimulus(5'h1f, 1'b1, 1'b1);
        checkOutput("clear res", 32'(res0), 32'h0);
        checkOutput("clear valid", 32'(op_valid0), 32'd0);

        // Invalid multi-key pattern, then a valid press of R3
        applyStimulus(5'b11100, 1'b0, 1'b1);
        checkOutput("err pulse", 32'(err0), 32'd1);
        applyStimulus(5'h1f, 1'b0, 1'b1);
        checkOutput("err one cycle", 32'(err0), 32'd0);
        applyStimulus(5'b10111, 1'b0, 1'b1);
        checkOutput("press R3 res", 32'(res0), 32'h7F00);
        applyStimulus(5'h1f, 1'b0, 1'b1);

        // Clear together with a press, key held through and after the clear
        applyStimulus(5'b11110, 1'b1, 1'b1);
        checkOutput("clear beats press", 32'(res0), 32'h0);
        applyStimulus(5'b11110, 1'b0, 1'b1);
        applyStimulus(5'b11110, 1'b0, 1'b1);
        checkOutput("held after clear", 32'(slot_idx0), 32'd0);
        applyStimulus(5'h1f, 1'b0, 1'b1);
        applyStimulus(5'b11110, 1'b0, 1'b1);
        checkOutput("repress after clear", 32'(res0), 32'h1200);
        applyStimulus(5'h1f, 1'b0, 1'b1);

        // Reset in the middle of a fill on the three-slot build
        applyStimulus(5'b11110, 1'b0, 1'b1);
        applyStimulus(5'h1f, 1'b0, 1'b0);
        applyStimulus(5'b11101, 1'b0, 1'b1);
        applyStimulus(5'h1f, 1'b0, 1'b1);
        applyStimulus(5'b11101, 1'b0, 1'b1);
        checkOutput("nops3 res", 32'(res2), 32'h330);
        checkOutput("nops3 idx", 32'(slot_idx2), 32'd2);
        checkOutput("nops3 valid", 32'(op_valid2), 32'd0);

        // Randomised traffic against the model
        for (int n = 0; n < 600; n++) begin
            src8 = {$urandom, $urandom};
            src4 = 20'($urandom);
            applyStimulus(randomKeys(),
                          ($urandom_range(0, 99) < 5),
                          !($urandom_range(0, 99) < 2));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
